// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame defaults common to rx and tx.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= RST_VAL;
            o_q  <= RST_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: recovers LSB-first frames from i_rx using the baud tick i_stick.
//
// state | meaning
// IDLE  | waiting for a 1->0 edge on the synchronized line (checked every clock)
// START | counting to mid start bit; a high sample there is a glitch
// DATA  | sampling DATA_BITS bits at mid-bit, shifting in LSB first
// STOP  | sampling the stop bit; high -> o_valid, low -> o_frame_err
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] TC_HALF  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] TC_FULL  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    rx_state_e            state, state_nx;
    logic                 rx_s, rx_prev, fall_edge;
    logic [CNT_W-1:0]     tick_cnt, tick_nx;
    logic [BIT_W-1:0]     bit_cnt, bit_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx, data_nx;
    logic                 valid_nx, ferr_nx;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_rx),
        .o_q    (rx_s)
    );

    // A line held low never re-arms the receiver; only a fresh 1->0 transition does.
    assign fall_edge = rx_prev & ~rx_s;

    always_comb begin
        state_nx = state;
        tick_nx  = tick_cnt;
        bit_nx   = bit_cnt;
        shreg_nx = shreg;
        data_nx  = o_data;
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (fall_edge) begin
                    state_nx = START;
                    tick_nx  = '0;
                end
            end
            START: begin
                if (i_stick) begin
                    if (tick_cnt == TC_HALF) begin
                        tick_nx = '0;
                        if (!rx_s) begin
                            state_nx = DATA;
                            bit_nx   = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        tick_nx = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_stick) begin
                    if (tick_cnt == TC_FULL) begin
                        shreg_nx = {rx_s, shreg[DATA_BITS-1:1]};
                        tick_nx  = '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_nx   = '0;
                            state_nx = STOP;
                        end else begin
                            bit_nx = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_nx = tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_stick) begin
                    if (tick_cnt == TC_FULL) begin
                        tick_nx  = '0;
                        state_nx = IDLE;
                        if (rx_s) begin
                            data_nx  = shreg;
                            valid_nx = 1'b1;
                        end else begin
                            ferr_nx = 1'b1;
                        end
                    end else begin
                        tick_nx = tick_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            rx_prev     <= 1'b1;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_nx;
            rx_prev     <= rx_s;
            tick_cnt    <= tick_nx;
            bit_cnt     <= bit_nx;
            shreg       <= shreg_nx;
            o_data      <= data_nx;
            o_valid     <= valid_nx;
            o_frame_err <= ferr_nx;
            o_busy      <= (state_nx != IDLE);
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver driven by the baud generator's tick (`o_stick` feeds `i_stick`).
- Recovers 8N1-style frames from the serial line `i_rx`.
- Presents each received byte as a one-cycle valid pulse, with a frame-error flag.
- Sits between the external serial pin and the byte-level consumer.

Parameters:
- DATA_BITS, 8: data bits per frame, LSB first.
- OVERSAMPLE, 16: `i_stick` ticks per bit period; must be even and ≥4.
- CNT_W, $clog2(OVERSAMPLE): tick counter width (derived; do not override).

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_stick  input  1  oversample tick from baud generator; one i_clk cycle wide.
- i_rx  input  1  asynchronous serial line; idle high.
- o_data  output  DATA_BITS  last correctly framed byte; held until next good frame.
- o_valid  output  1  one-cycle pulse, o_data updated in same cycle.
- o_frame_err  output  1  one-cycle pulse, stop bit sampled low.
- o_busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (async assert, sync release): all outputs are 0 and the FSM is IDLE. Tick counter, bit counter and shift register are 0. Synchronizer flops reset to 1 (line idle).
- `i_rx` passes through a 2-FF synchronizer; `rx_s` lags `i_rx` by 2 clocks.
- Falling edge is defined as `rx_s` = 0 with the previous `rx_s` = 1.
- All counting and sampling below happens only on cycles where `i_stick` = 1, except IDLE edge detection, which runs every clock.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Falling edge → START; tick_cnt ← 0.
  - A line held low (e.g. after a break) does not retrigger; a new 1→0 edge is required.
- START:
  - On the tick where tick_cnt = OVERSAMPLE/2-1, sample `rx_s`.
  - Sample 0 → DATA; tick_cnt ← 0; bit_cnt ← 0.
  - Sample 1 → treat as glitch; return to IDLE with no output pulse.
- DATA:
  - On the tick where tick_cnt = OVERSAMPLE-1, sample `rx_s`.
  - Shift the sample in LSB-first: shreg ← {rx_s, shreg[DATA_BITS-1:1]}.
  - Then tick_cnt ← 0 and bit_cnt increments.
  - After the sample with bit_cnt = DATA_BITS-1 → STOP.
- STOP:
  - On the tick where tick_cnt = OVERSAMPLE-1, sample `rx_s`.
  - Sample 1: o_data ← shreg and o_valid = 1 for exactly the next clock.
  - Sample 0: o_frame_err = 1 for the next clock; o_data unchanged.
  - Either way → IDLE.
- Latency: o_valid rises 1 clock after the i_stick that samples the stop bit.
- tick_cnt wraps modulo OVERSAMPLE inside each state; no counter ever overflows CNT_W.
- o_valid and o_frame_err are never both high.
- o_busy is registered: it is 1 from the clock after edge detection until the return to IDLE.
- `i_stick` held constantly high is legal (one tick per clock). If `i_stick` stops, the FSM freezes in its current state.
- Reset asserted mid-frame: immediate return to IDLE; the partial byte is discarded with no pulses; o_data clears to 0.
- A back-to-back frame whose start edge arrives during or right after STOP is caught, because the IDLE edge detector runs every clock.

Decomposition:
- Package uart_pkg holds:
  - enum rx_state_e {IDLE, START, DATA, STOP} as a 2-bit typedef;
  - localparam defaults UART_DATA_BITS = 8 and UART_OVERSAMPLE = 16, shared with the future uart_tx.
- Sub-module sync_2ff (parameter RST_VAL = 1) holds the synchronizer flops, reusable by other async inputs.

Test Plan:
- Bench setup: i_stick pulses every 4 clocks (bit = 64 clocks).
  - Send 0xA5 with a good stop bit → exactly one o_valid pulse, o_data = 0xA5, o_frame_err = 0.
  - The o_valid pulse lands 1 clock after the stop-sample tick.
- Glitch: i_rx low for 12 clocks (3 ticks), then high → no pulses; o_busy returns to 0 within 8 ticks; o_data unchanged.
- Frame error: send 0x3C with stop bit = 0 → o_frame_err pulse, no o_valid, o_data keeps the previous value (0xA5).
- Back-to-back: send 0x00 then 0xFF with zero idle gap → two o_valid pulses with o_data 0x00 then 0xFF; no errors.
- Reset mid-frame: assert i_rst_n = 0 during data bit 4 of 0x5A, release, send 0x81 → no pulse for 0x5A; o_data = 0x00 after reset; then o_valid with 0x81.
- i_stick tied high: send 0x7E at a 16-clock bit period → o_valid with o_data = 0x7E.
